// File: rtl/iq_free_list_pkg.sv
// Shared issue-queue types and sizing for the free-list slice.
// No logic; latency n/a.
// No flow control; types only.
package iq_free_list_pkg;

    localparam int SIZE_ISSUEQ     = 32;
    localparam int SIZE_ISSUEQ_LOG = $clog2(SIZE_ISSUEQ);
    localparam int DISPATCH_WIDTH  = 4;
    localparam int ISSUE_WIDTH     = 4;

    typedef struct packed {
        logic                       valid;
        logic [SIZE_ISSUEQ_LOG-1:0] id;
    } iqEntryPkt;

endpackage

// File: rtl/iq_lane_rank.sv
// Prefix popcount: rank of each lane among active lanes, plus total active.
// Purely combinational, zero latency.
// No flow control.
module iq_lane_rank #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic [WIDTH-1:0]            laneMask,
    output logic [WIDTH-1:0][CNT_W-1:0] laneRank,
    output logic [CNT_W-1:0]            laneTotal
);

    always_comb begin
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < WIDTH; k++) begin
            laneRank[k] = acc;
            acc         = acc + CNT_W'(laneMask[k]);
        end
        laneTotal = acc;
    end

endmodule

// File: rtl/iq_free_list.sv
// Circular free list of issue-queue entry IDs: multi-lane allocate, multi-lane return.
// Offers are combinational from registered state; pointer/count updates land next edge.
// Stalls (offers nothing poppable) when active lanes exceed free entries; returns never stall.
module iq_free_list
    import iq_free_list_pkg::*;
#(
    parameter int SIZE_ISSUEQ       = iq_free_list_pkg::SIZE_ISSUEQ,
    parameter int DISPATCH_WIDTH    = iq_free_list_pkg::DISPATCH_WIDTH,
    parameter int ISSUE_WIDTH       = iq_free_list_pkg::ISSUE_WIDTH,
    parameter bit CHECK_STALL_READY = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush_i,
    input  logic                              dispatchReady_i,
    input  logic [DISPATCH_WIDTH-1:0]         dispatchLaneActive_i,
    output iqEntryPkt [DISPATCH_WIDTH-1:0]    freeEntry_o,
    input  iqEntryPkt [ISSUE_WIDTH-1:0]       grantedEntry_i,
    output logic [$clog2(SIZE_ISSUEQ):0]      freeCount_o,
    output logic                              stall_o
);

    localparam int LOG    = $clog2(SIZE_ISSUEQ);
    localparam int CNT_W  = LOG + 1;
    localparam int DCNT_W = $clog2(DISPATCH_WIDTH + 1);
    localparam int GCNT_W = $clog2(ISSUE_WIDTH + 1);

    logic [LOG-1:0]   freeBuf [SIZE_ISSUEQ];
    logic [LOG-1:0]   headPtr;
    logic [LOG-1:0]   tailPtr;
    logic [CNT_W-1:0] freeCount;

    logic [DISPATCH_WIDTH-1:0][DCNT_W-1:0] dispRank;
    logic [DCNT_W-1:0]                     dispTotal;
    logic [ISSUE_WIDTH-1:0]                grantMask;
    logic [ISSUE_WIDTH-1:0][GCNT_W-1:0]    grantRank;
    logic [GCNT_W-1:0]                     grantTotal;

    logic             doPop;
    logic [CNT_W-1:0] popCount;
    logic [CNT_W-1:0] pushCount;
    logic [CNT_W:0]   countSum;
    logic             dupGrant;

    always_comb begin
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
            grantMask[j] = grantedEntry_i[j].valid;
        end
    end

    iq_lane_rank #(.WIDTH(DISPATCH_WIDTH), .CNT_W(DCNT_W)) u_dispRank (
        .laneMask  (dispatchLaneActive_i),
        .laneRank  (dispRank),
        .laneTotal (dispTotal)
    );

    iq_lane_rank #(.WIDTH(ISSUE_WIDTH), .CNT_W(GCNT_W)) u_grantRank (
        .laneMask  (grantMask),
        .laneRank  (grantRank),
        .laneTotal (grantTotal)
    );

    // Lane k reads the slot rank(k) past head; valid only if that slot holds a free ID.
    always_comb begin
        logic [LOG-1:0] rdIdx;
        rdIdx = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            rdIdx                = headPtr + LOG'(dispRank[k]);
            freeEntry_o[k].id    = freeBuf[rdIdx];
            freeEntry_o[k].valid = dispatchLaneActive_i[k] && (CNT_W'(dispRank[k]) < freeCount);
        end
    end

    assign stall_o     = CNT_W'(dispTotal) > freeCount;
    assign freeCount_o = freeCount;
    assign doPop       = dispatchReady_i && !stall_o;
    assign popCount    = doPop ? CNT_W'(dispTotal) : '0;
    assign pushCount   = CNT_W'(grantTotal);
    assign countSum    = {1'b0, freeCount} - {1'b0, popCount} + {1'b0, pushCount};

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            freeCount <= CNT_W'(SIZE_ISSUEQ);
            for (int i = 0; i < SIZE_ISSUEQ; i++) begin
                freeBuf[i] <= LOG'(i);
            end
        end else begin
            headPtr   <= headPtr + LOG'(popCount);
            tailPtr   <= tailPtr + LOG'(pushCount);
            freeCount <= freeCount - popCount + pushCount;
            for (int j = 0; j < ISSUE_WIDTH; j++) begin
                if (grantedEntry_i[j].valid) begin
                    freeBuf[tailPtr + LOG'(grantRank[j])] <= grantedEntry_i[j].id;
                end
            end
        end
    end

    // Occupancy is defined by distance from head, so a stale slot never counts as free.
    always_comb begin
        logic [LOG-1:0] slotOff;
        slotOff  = '0;
        dupGrant = 1'b0;
        for (int i = 0; i < SIZE_ISSUEQ; i++) begin
            slotOff = LOG'(i) - headPtr;
            if ({1'b0, slotOff} < freeCount) begin
                for (int j = 0; j < ISSUE_WIDTH; j++) begin
                    if (grantedEntry_i[j].valid && (grantedEntry_i[j].id == freeBuf[i])) begin
                        dupGrant = 1'b1;
                    end
                end
            end
        end
    end

    overflowChk: assert property (@(posedge clk) disable iff (reset || flush_i)
        countSum <= (CNT_W + 1)'(SIZE_ISSUEQ));

    dupGrantChk: assert property (@(posedge clk) disable iff (reset || flush_i)
        !dupGrant);

    if (CHECK_STALL_READY) begin : g_stallReadyChk
        stallReadyChk: assert property (@(posedge clk) disable iff (reset || flush_i)
            !(dispatchReady_i && stall_o));
    end

endmodule

// File: tb/tb_iq_free_list.sv
// Bench for iq_free_list: queue-based reference model, expected offers queued per cycle,
// a negedge monitor compares them against the DUT outputs.
module tb_iq_free_list;
    import iq_free_list_pkg::*;

    localparam int N  = SIZE_ISSUEQ;
    localparam int DW = DISPATCH_WIDTH;
    localparam int IW = ISSUE_WIDTH;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     flush = 1'b0;
    logic                     dispatchReady = 1'b0;
    logic [DW-1:0]            laneActive = '0;
    iqEntryPkt [DW-1:0]       freeEntry;
    iqEntryPkt [IW-1:0]       granted = '0;
    logic [SIZE_ISSUEQ_LOG:0] freeCount;
    logic                     stall;

    iq_free_list #(.CHECK_STALL_READY(1'b0)) dut (
        .clk                  (clk),
        .reset                (reset),
        .flush_i              (flush),
        .dispatchReady_i      (dispatchReady),
        .dispatchLaneActive_i (laneActive),
        .freeEntry_o          (freeEntry),
        .grantedEntry_i       (granted),
        .freeCount_o          (freeCount),
        .stall_o              (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [DW-1:0] vld;
        int            id [DW];
        bit            stall;
        int            cnt;
    } exp_t;

    exp_t expQ [$];
    int   freeQ [$];
    int   allocQ [$];
    int   total = 0;
    int   bad = 0;
    int   zeroG [IW] = '{default: 0};

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic model_reset();
        freeQ.delete();
        allocQ.delete();
        for (int i = 0; i < N; i++) freeQ.push_back(i);
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check({e.name, ".count"}, int'(freeCount), e.cnt);
                check({e.name, ".stall"}, int'(stall), int'(e.stall));
                for (int k = 0; k < DW; k++) begin
                    check($sformatf("%s.lane%0d.valid", e.name, k), int'(freeEntry[k].valid), int'(e.vld[k]));
                    if (e.vld[k]) check($sformatf("%s.lane%0d.id", e.name, k), int'(freeEntry[k].id), e.id[k]);
                end
            end
        end
    end

    // clr: 0 none, 1 flush, 2 reset. Called just after a posedge; returns just after the next.
    task automatic step(input logic [DW-1:0] lanes, input bit rdy, input logic [IW-1:0] gv,
                        input int gid [IW], input int clr, input string nm);
        exp_t e;
        int   r;
        int   n;
        int   idxq [$];
        laneActive    = lanes;
        dispatchReady = rdy;
        flush         = (clr == 1);
        reset         = (clr == 2);
        for (int j = 0; j < IW; j++) begin
            granted[j].valid = gv[j];
            granted[j].id    = gid[j][SIZE_ISSUEQ_LOG-1:0];
        end
        n       = $countones(lanes);
        e.name  = nm;
        e.cnt   = freeQ.size();
        e.stall = n > freeQ.size();
        r = 0;
        for (int k = 0; k < DW; k++) begin
            e.vld[k] = lanes[k] && (r < freeQ.size());
            e.id[k]  = e.vld[k] ? freeQ[r] : -1;
            if (lanes[k]) r++;
        end
        expQ.push_back(e);
        @(posedge clk);
        #1;
        if (clr != 0) begin
            model_reset();
        end else begin
            if (rdy && !e.stall) begin
                for (int i = 0; i < n; i++) allocQ.push_back(freeQ.pop_front());
            end
            for (int j = 0; j < IW; j++) begin
                if (gv[j]) begin
                    freeQ.push_back(gid[j]);
                    idxq = allocQ.find_first_index(x) with (x == gid[j]);
                    if (idxq.size() > 0) allocQ.delete(idxq[0]);
                end
            end
        end
        reset = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] lanes;
        logic [IW-1:0] gv;
        int            gid [IW];
        int            tmp [$];
        int            p;
        bit            rdy;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Full-width allocate from reset, then next block of IDs.
        step(4'b1111, 1'b1, '0, zeroG, 0, "alloc4");
        step(4'b1111, 1'b0, '0, zeroG, 0, "alloc4_next");

        // Sparse lanes after reset.
        step(4'b0000, 1'b0, '0, zeroG, 2, "rst_a");
        step(4'b1010, 1'b1, '0, zeroG, 0, "sparse");
        step(4'b0000, 1'b0, '0, zeroG, 0, "sparse_after");

        // Drain to 2, then a 3-lane request must stall and be ignored.
        step(4'b0000, 1'b0, '0, zeroG, 2, "rst_b");
        for (int i = 0; i < 7; i++) step(4'b1111, 1'b1, '0, zeroG, 0, "drain");
        step(4'b0011, 1'b1, '0, zeroG, 0, "drain_tail");
        step(4'b0111, 1'b1, '0, zeroG, 0, "stall3");
        step(4'b0000, 1'b0, '0, zeroG, 0, "stall3_after");

        // Empty list: returns land the same cycle a 1-lane dispatch stalls.
        step(4'b0011, 1'b1, '0, zeroG, 0, "drain_last");
        step(4'b0001, 1'b1, 4'b0101, '{5, 0, 9, 0}, 0, "grant_empty");
        step(4'b0001, 1'b0, '0, zeroG, 0, "grant_visible");

        // Reset in the middle of traffic discards the pending pop/push.
        step(4'b1111, 1'b1, 4'b0011, '{allocQ[0], allocQ[1], 0, 0}, 2, "mid_reset");
        step(4'b1111, 1'b0, '0, zeroG, 0, "after_reset");

        // Random pop/push traffic across pointer wrap.
        for (int c = 0; c < 100; c++) begin
            lanes = 4'($urandom_range(0, 15));
            rdy   = ($countones(lanes) <= freeQ.size()) && ($urandom_range(0, 3) != 0);
            tmp   = allocQ;
            gv    = '0;
            for (int j = 0; j < IW; j++) begin
                gid[j] = 0;
                if (tmp.size() > 0 && $urandom_range(0, 1) == 1) begin
                    p      = $urandom_range(0, tmp.size() - 1);
                    gid[j] = tmp[p];
                    tmp.delete(p);
                    gv[j]  = 1'b1;
                end
            end
            step(lanes, rdy, gv, gid, 0, "rand");
        end
        check("conservation", int'(freeCount) + allocQ.size(), N);

        // Flush with traffic in flight restores the identity list.
        gv = '0;
        for (int j = 0; j < IW; j++) gid[j] = 0;
        if (allocQ.size() > 0) begin
            gv[0]  = 1'b1;
            gid[0] = allocQ[0];
        end
        step(4'b0011, (freeQ.size() >= 2), gv, gid, 1, "flush");
        step(4'b1111, 1'b0, '0, zeroG, 0, "after_flush");

        laneActive    = '0;
        dispatchReady = 1'b0;
        granted       = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("expq_drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
